// File: rtl/tqvp_video_capture.sv
// rtl/tqvp_video_capture.sv - sync-locked video timing measurement and single-pixel capture peripheral
module tqvp_video_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] XY_MAX = 11'h7FF;

  state_t      state_q, state_d;
  logic [3:0]  ctrl;
  logic        capture_done, lock_lost;
  logic [10:0] target_x, target_y;
  logic [10:0] pos_x, pos_y, line_period, frame_lines;
  logic [15:0] frame_count;
  logic [5:0]  capture;
  logic [1:0]  sync_q, sync_prev, sync_norm, sync_edge;
  logic        enable, polarity, capture_arm, irq_en;
  logic        wr_any, ctrl_wr, status_wr, target_wr;
  logic        vs_edge, hs_edge, trigger, lost_evt;
  logic [10:0] x_inc, y_inc;
  logic        unused_inputs;

  assign enable      = ctrl[0];
  assign polarity    = ctrl[1];
  assign capture_arm = ctrl[2];
  assign irq_en      = ctrl[3];

  assign wr_any    = (data_write_n != 2'b11);
  assign ctrl_wr   = wr_any && (address == 6'h00);
  assign status_wr = wr_any && (address == 6'h04);
  assign target_wr = (data_write_n == 2'b10) && (address == 6'h08);

  // Syncs are compared in "active = 1" form so edge detection is polarity-agnostic.
  assign sync_norm = polarity ? sync_q : ~sync_q;
  assign sync_edge = sync_norm & ~sync_prev;
  assign vs_edge   = sync_edge[1];
  assign hs_edge   = sync_edge[0];

  assign x_inc = (pos_x == XY_MAX) ? pos_x : pos_x + 11'd1;
  assign y_inc = (pos_y == XY_MAX) ? pos_y : pos_y + 11'd1;

  assign trigger = (state_q == ST_LOCKED) && capture_arm &&
                   (pos_x == target_x) && (pos_y == target_y);

  always_comb begin
    state_d  = state_q;
    lost_evt = 1'b0;
    case (state_q)
      ST_OFF:    if (enable) state_d = ST_SEARCH;
      ST_SEARCH: if (vs_edge) state_d = ST_LOCKED;
      ST_LOCKED: begin
        if (!hs_edge && (x_inc == XY_MAX)) begin
          state_d  = ST_SEARCH;
          lost_evt = 1'b1;
        end
      end
      default:   state_d = ST_OFF;
    endcase
    if (!enable) begin
      state_d  = ST_OFF;
      lost_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl         <= 4'd0;
      capture_done <= 1'b0;
      lock_lost    <= 1'b0;
      target_x     <= 11'd0;
      target_y     <= 11'd0;
      pos_x        <= 11'd0;
      pos_y        <= 11'd0;
      line_period  <= 11'd0;
      frame_lines  <= 11'd0;
      frame_count  <= 16'd0;
      capture      <= 6'd0;
      sync_q       <= 2'd0;
      sync_prev    <= 2'd0;
    end else begin
      sync_q    <= ui_in[7:6];
      sync_prev <= sync_norm;

      case (state_q)
        ST_LOCKED: begin
          pos_x <= hs_edge ? 11'd0 : x_inc;
          if (hs_edge) line_period <= pos_x + 11'd1;
          // vsync owns y when both edges land together; hsync still owns x.
          if (vs_edge) begin
            pos_y       <= 11'd0;
            frame_lines <= pos_y;
            frame_count <= frame_count + 16'd1;
          end else if (hs_edge) begin
            pos_y <= y_inc;
          end
        end
        ST_SEARCH: begin
          if (vs_edge) begin
            pos_x <= 11'd0;
            pos_y <= 11'd0;
          end
        end
        default: begin
          pos_x <= 11'd0;
          pos_y <= 11'd0;
        end
      endcase

      if (trigger) capture <= ui_in[5:0];
      capture_done <= trigger  | (capture_done & ~(status_wr & data_in[1]));
      lock_lost    <= lost_evt | (lock_lost    & ~(status_wr & data_in[2]));

      if ((state_q != ST_OFF) && !enable) ctrl[2] <= 1'b0;
      if (ctrl_wr) ctrl <= data_in[3:0];
      if (trigger) ctrl[2] <= 1'b0;

      if (target_wr) begin
        target_x <= data_in[10:0];
        target_y <= data_in[26:16];
      end
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h00:   data_out = {28'd0, ctrl};
      6'h04:   data_out = {29'd0, lock_lost, capture_done, (state_q == ST_LOCKED)};
      6'h08:   data_out = {5'd0, target_y, 5'd0, target_x};
      6'h0C:   data_out = {26'd0, capture};
      6'h10:   data_out = {21'd0, line_period};
      6'h14:   data_out = {21'd0, frame_lines};
      6'h18:   data_out = {16'd0, frame_count};
      6'h1C:   data_out = {5'd0, pos_y, 5'd0, pos_x};
      default: data_out = 32'd0;
    endcase
  end

  assign uo_out         = {2'b00, capture};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_en & (capture_done | lock_lost);

  assign unused_inputs = &{1'b0, data_read_n, data_in[31:27], data_in[15:11]};

endmodule

// File: tb/tb_tqvp_video_capture.sv
// tb/tb_tqvp_video_capture.sv - scoreboard bench driving randomized sync/pixel streams into tqvp_video_capture
module tb_tqvp_video_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #20 clk = ~clk;

  tqvp_video_capture dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  localparam int K_DATA = 0;
  localparam int K_IRQ  = 1;
  localparam int K_UO   = 2;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passed = 0;
  event        sample_ev;
  logic        pol_cur;

  logic [31:0] m_exp, m_act;
  int          m_kind;
  string       m_name;

  always begin
    @(sample_ev);
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_underflow: sample with no expectation queued");
    end else begin
      m_exp  = exp_q.pop_front();
      m_kind = kind_q.pop_front();
      m_name = name_q.pop_front();
      case (m_kind)
        K_IRQ:   m_act = {31'd0, user_interrupt};
        K_UO:    m_act = {24'd0, uo_out};
        default: m_act = data_out;
      endcase
      if (m_act === m_exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
    end
  end

  task automatic expect_val(input int kind, input logic [5:0] addr, input logic [31:0] exp,
                            input string nm, input bit hold);
    address     = addr;
    data_read_n = (kind == K_DATA) ? 2'b00 : 2'b11;
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(nm);
    #1;
    ->sample_ev;
    #1;
    data_read_n = 2'b11;
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input logic [7:0] v);
    ui_in = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] vid(input logic vs, input logic hs, input logic [5:0] rgb);
    logic a, b;
    a = pol_cur ? vs : ~vs;
    b = pol_cur ? hs : ~hs;
    return {a, b, rgb};
  endfunction

  task automatic reg_write(input logic [5:0] addr, input logic [31:0] d, input logic [1:0] wn);
    address      = addr;
    data_in      = d;
    data_write_n = wn;
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Frame: vsync on samples 0..2, line k (1..N) begins with hsync at d+(k-1)*L.
  // Pixel (x,y) is the sample two after the sync sample that starts its line.
  task automatic run_stream(input int len, input int lines, input int d, input int nframes,
                            input int tx, input int ty, input logic [5:0] pix);
    int          f_len, pix_idx;
    logic [5:0]  rgb;
    f_len   = d + lines * len;
    pix_idx = d + (ty - 1) * len + 2 + tx;
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < f_len; c++) begin
        rgb = 6'($urandom);
        if (f == 0 && c == pix_idx) rgb = pix;
        else if (rgb == pix) rgb = rgb ^ 6'h01;
        step(vid(c < 3, (c >= d) && (((c - d) % len) < 2), rgb));
      end
    end
    step(vid(1'b0, 1'b0, 6'd0));
  endtask

  task automatic run_case(input logic pol, input int len, input int lines, input int d,
                          input logic arm, input logic irq, input int tx, input int ty,
                          input logic [5:0] pix);
    logic [10:0] x11, y11, n11;
    x11 = 11'(tx);
    y11 = 11'(ty);
    n11 = 11'(lines);
    pulse_reset();
    pol_cur = pol;
    ui_in   = vid(1'b0, 1'b0, 6'd0);
    reg_write(6'h00, 32'({irq, 1'b0, pol, 1'b0}), 2'b00);
    reg_write(6'h08, {5'd0, y11, 5'd0, x11}, 2'b10);
    reg_write(6'h08, 32'hFFFF_FFFF, 2'b01);
    expect_val(K_DATA, 6'h08, {5'd0, y11, 5'd0, x11}, "target_after_narrow_write", 0);
    reg_write(6'h00, 32'({irq, arm, pol, 1'b1}), 2'b00);
    repeat (3) step(vid(1'b0, 1'b0, 6'd0));
    run_stream(len, lines, d, 3, tx, ty, pix);

    expect_val(K_DATA, 6'h00, 32'({irq, 1'b0, pol, 1'b1}), "ctrl_arm_cleared", 0);
    expect_val(K_DATA, 6'h04, 32'({arm, 1'b1}), "status_locked", 0);
    expect_val(K_DATA, 6'h0C, arm ? 32'(pix) : 32'd0, "capture", 0);
    expect_val(K_UO, 6'h00, arm ? 32'(pix) : 32'd0, "uo_out", 0);
    expect_val(K_IRQ, 6'h00, 32'(irq & arm), "irq_capture", 0);
    expect_val(K_DATA, 6'h10, 32'(len), "line_period", 0);
    expect_val(K_DATA, 6'h14, 32'(lines), "frame_lines", 0);
    expect_val(K_DATA, 6'h18, 32'd2, "frame_count", 0);
    if (arm) begin
      reg_write(6'h04, 32'h2, 2'b00);
      expect_val(K_DATA, 6'h04, 32'h1, "status_after_w1c_done", 0);
      expect_val(K_IRQ, 6'h00, 32'd0, "irq_after_w1c_done", 0);
    end

    repeat (2100) step(vid(1'b0, 1'b0, 6'd0));
    expect_val(K_DATA, 6'h04, 32'h4, "status_lock_lost", 0);
    expect_val(K_IRQ, 6'h00, 32'(irq), "irq_lock_lost", 0);
    expect_val(K_DATA, 6'h1C, {5'd0, n11, 5'd0, 11'h7FF}, "cur_pos_saturated", 0);
    reg_write(6'h04, 32'h4, 2'b01);
    expect_val(K_DATA, 6'h04, 32'h0, "status_after_w1c_lost", 0);
    expect_val(K_IRQ, 6'h00, 32'd0, "irq_after_w1c_lost", 0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [5:0] regs [9];
    regs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h24};
    for (int i = 0; i < 9; i++)
      expect_val(K_DATA, regs[i], 32'd0, $sformatf("%s_reg_%02h", tag, regs[i]), 1);
    expect_val(K_UO, 6'h00, 32'd0, {tag, "_uo_out"}, 1);
    expect_val(K_IRQ, 6'h00, 32'd0, {tag, "_irq"}, 1);
  endtask

  initial begin
    int len, lines, d, tx, ty;
    logic pol, irq;
    logic [5:0] pix;

    rst_n        = 1'b0;
    ui_in        = 8'd0;
    address      = 6'd0;
    data_in      = 32'd0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    pol_cur      = 1'b1;

    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_case(1'b1, 100, 10, 5, 1'b0, 1'b0, 0, 1, 6'd0);
    run_case(1'b0, 100, 10, 5, 1'b0, 1'b1, 0, 1, 6'd0);
    run_case(1'b1, 60, 6, 4, 1'b1, 1'b1, 5, 3, 6'h2A);
    for (int i = 0; i < 3; i++) begin
      pol   = 1'($urandom);
      irq   = 1'($urandom);
      len   = $urandom_range(20, 120);
      lines = $urandom_range(3, 12);
      d     = $urandom_range(4, 8);
      tx    = $urandom_range(0, len - 3);
      ty    = $urandom_range(1, lines);
      pix   = 6'($urandom);
      run_case(pol, len, lines, d, 1'b1, irq, tx, ty, pix);
    end

    // Coincident hsync/vsync leading edges after a few counted lines.
    pulse_reset();
    pol_cur = 1'b1;
    ui_in   = vid(1'b0, 1'b0, 6'd0);
    reg_write(6'h00, 32'h3, 2'b00);
    repeat (3) step(vid(1'b0, 1'b0, 6'd0));
    repeat (3) step(vid(1'b1, 1'b0, 6'd0));
    repeat (5) step(vid(1'b0, 1'b0, 6'd0));
    for (int j = 0; j < 3; j++) begin
      repeat (2) step(vid(1'b0, 1'b1, 6'd0));
      repeat (18) step(vid(1'b0, 1'b0, 6'd0));
    end
    repeat (7) step(vid(1'b0, 1'b0, 6'd0));
    repeat (2) step(vid(1'b1, 1'b1, 6'd0));
    expect_val(K_DATA, 6'h1C, 32'd0, "coincident_cur_pos", 0);
    expect_val(K_DATA, 6'h18, 32'd1, "coincident_frame_count", 0);
    expect_val(K_DATA, 6'h14, 32'd3, "coincident_frame_lines", 0);
    expect_val(K_DATA, 6'h10, 32'd27, "coincident_line_period", 0);

    // Reset mid-frame after a capture has completed.
    pulse_reset();
    pol_cur = 1'b1;
    ui_in   = vid(1'b0, 1'b0, 6'd0);
    reg_write(6'h00, 32'hA, 2'b00);
    reg_write(6'h08, {5'd0, 11'd1, 5'd0, 11'd2}, 2'b10);
    reg_write(6'h00, 32'hF, 2'b00);
    repeat (3) step(vid(1'b0, 1'b0, 6'd0));
    run_stream(30, 4, 4, 1, 2, 1, 6'h15);
    expect_val(K_DATA, 6'h0C, 32'h15, "abort_pre_capture", 0);
    repeat (5) step(vid(1'b1, 1'b0, 6'h3F));
    rst_n = 1'b0;
    check_all_zero("midframe_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(vid(1'b0, 1'b0, 6'h3F));
    expect_val(K_DATA, 6'h0C, 32'd0, "abort_no_stale_capture", 0);
    expect_val(K_UO, 6'h00, 32'd0, "abort_no_stale_uo", 0);

    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tqvp_video_capture.md
TQVP_VIDEO_CAPTURE -- requirements
Module: tqvp_video_capture

Interface
REQ-001 SHALL have port clk, input, 1, project clock (64 MHz nominal).
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port ui_in, input, 8, captured video: [7]=vsync, [6]=hsync, [5:4]=B, [3:2]=G, [1:0]=R.
REQ-004 SHALL have port uo_out, output, 8, {2'b00, CAPTURE[5:0]}.
REQ-005 SHALL have port address, input, 6, register byte address.
REQ-006 SHALL have port data_in, input, 32, write data.
REQ-007 SHALL have port data_write_n, input, 2, 11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
REQ-008 SHALL have port data_read_n, input, 2, read strobe; unused.
REQ-009 SHALL have port data_out, output, 32, read data; combinational from address.
REQ-010 SHALL have port data_ready, output, 1, tied to 1.
REQ-011 SHALL have port user_interrupt, output, 1, level interrupt.

Function
REQ-012 SHALL provide registers:
- 0x00 CTRL[3:0], RW: b0 enable, b1 polarity (1 = active-high sync), b2 capture_arm, b3 irq_en.
- 0x04 STATUS[2:0]: b0 locked (RO), b1 capture_done (W1C), b2 lock_lost (W1C).
- 0x08 TARGET, RW: x [10:0], y [26:16].
- 0x0C CAPTURE[5:0], RO.
- 0x10 LINE_PERIOD[10:0], RO.
- 0x14 FRAME_LINES[10:0], RO.
- 0x18 FRAME_COUNT[15:0], RO.
- 0x1C CUR_POS, RO: x [10:0], y [26:16].
- Other addresses SHALL read 0.
REQ-013 SHALL accept CTRL and STATUS writes of any width from data_in[7:0]; TARGET SHALL update only on 32-bit writes; other widths to TARGET SHALL be ignored.
REQ-014 SHALL register ui_in[7:6] once; a sync input is normalised as s = polarity ? raw : ~raw; a leading edge is s=1 while the previous s=0.
REQ-015 SHALL implement FSM OFF/SEARCH/LOCKED:
- OFF: while enable=0; x=y=0; locked=0.
- OFF -> SEARCH on enable=1.
- SEARCH -> LOCKED on a vsync leading edge; x and y are cleared that cycle.
- LOCKED -> SEARCH when x reaches 2047; lock_lost is set.
- Any state -> OFF on the cycle after enable is cleared; capture_arm is cleared with it.
REQ-016 In LOCKED, x SHALL increment every clock, saturating at 2047.
REQ-017 On an hsync leading edge, x SHALL be set to 0, y SHALL increment (saturating at 2047), and LINE_PERIOD SHALL be set to x+1.
REQ-018 On a vsync leading edge in LOCKED, y SHALL be set to 0, FRAME_LINES SHALL be set to y, and FRAME_COUNT SHALL increment, wrapping 65535 -> 0.
REQ-019 When hsync and vsync leading edges coincide, vsync SHALL govern y (y=0), and hsync SHALL still clear x and update LINE_PERIOD.
REQ-020 Capture trigger: LOCKED, capture_arm=1, and registered x==TARGET.x and y==TARGET.y.
REQ-021 On the clock after the trigger cycle:
- CAPTURE SHALL hold ui_in[5:0] as sampled in the trigger cycle.
- capture_done SHALL be 1.
- capture_arm SHALL be 0.
REQ-022 A hardware set of a STATUS bit SHALL take precedence over a simultaneous W1C of the same bit.
REQ-023 user_interrupt SHALL equal irq_en & (capture_done | lock_lost).

Reset
REQ-024 rst_n low SHALL immediately set all registers, counters and flags to 0, force state OFF, and drive uo_out=0 and user_interrupt=0.
REQ-025 Assertion of rst_n mid-frame or mid-capture SHALL abort the operation, with no stale CAPTURE data retained.

Verification
REQ-026 Reset: assert rst_n=0 with no clock edge -> data_out=0 at every address, user_interrupt=0, uo_out=0.
REQ-027 Lock and measure: CTRL=0x3; drive 100-clock lines, 10 lines per frame, 3 vsync pulses -> LINE_PERIOD=100, FRAME_LINES=10, FRAME_COUNT=2, STATUS=0x1.
REQ-028 Capture: TARGET x=5, y=3; CTRL=0xF; RGB=0x2A at that pixel only -> CAPTURE=0x2A, uo_out=0x2A, STATUS b1=1, user_interrupt=1; write 0x2 to 0x04 -> interrupt 0; CTRL b2 reads 0.
REQ-029 Loss of lock: stop hsync after lock -> after x reaches 2047, STATUS=0x4, state SEARCH, user_interrupt=1 when irq_en=1.
REQ-030 Coincident edges: hsync and vsync leading edges in the same cycle -> CUR_POS x=0, y=0, FRAME_COUNT incremented once.
REQ-031 Polarity: polarity=0 with active-low sync stream -> same LINE_PERIOD and FRAME_LINES as REQ-027.
